// File: rtl/line_mem_responder_if.sv
// Line-fill / write-back bus between a cache (master) and main memory (slave).
// Carries the request, write-beat and response handshakes.
interface line_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_last;

  modport master (
    output req_valid, req_write, req_addr,
    output wdata_valid, wdata, resp_ready,
    input  req_ready, wdata_ready,
    input  resp_valid, resp_data, resp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  wdata_valid, wdata, resp_ready,
    output req_ready, wdata_ready,
    output resp_valid, resp_data, resp_last
  );
endinterface

// File: rtl/line_mem_responder.sv
// Main-memory responder: one line request at a time, fixed latency, beat streaming.
// Ports: clk, rst (async active-low), bus (slave side of line_mem_responder_if).
module line_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int BEATS       = 4,
  parameter int LATENCY     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  line_mem_responder_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int BW    = $clog2(BEATS);
  localparam int LINEW = AW - BW;
  localparam int LW    = $clog2(LATENCY + 1);
  localparam logic [LW-1:0] LAT_INIT  = LW'(LATENCY - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, RWAIT, RDATA, WDATA, WWAIT
  } state_t;

  state_t           state_q, state_d;
  logic [LINEW-1:0] line_q, line_d;
  logic [BW-1:0]    beat_q, beat_d, beat_nx;
  logic [LW-1:0]    lat_q, lat_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ack_q, ack_d;
  logic             mem_we;

  // Never reset: contents survive reset so benches can preload them.
  logic [31:0] mem [DEPTH_WORDS];

  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[BW+1:0]};

  assign beat_nx = beat_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[{line_q, beat_q}] <= bus.wdata;
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          line_d = bus.req_addr[AW+1:BW+2];
          beat_d = '0;
          if (bus.req_write) begin
            state_d = WDATA;
          end else begin
            state_d = RWAIT;
            lat_d   = LAT_INIT;
          end
        end
      end
      RWAIT: begin
        if (lat_q == '0) begin
          state_d = RDATA;
          rdata_d = mem[{line_q, beat_q}];
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RDATA: begin
        if (bus.resp_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            beat_d  = '0;
            // Idle and write-ack cycles present zero data.
            rdata_d = '0;
          end else begin
            beat_d  = beat_nx;
            rdata_d = mem[{line_q, beat_nx}];
          end
        end
      end
      WDATA: begin
        if (bus.wdata_valid) begin
          mem_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = WWAIT;
            lat_d   = LAT_INIT;
            beat_d  = '0;
          end else begin
            beat_d = beat_nx;
          end
        end
      end
      WWAIT: begin
        if (ack_q) begin
          if (bus.resp_ready) begin
            state_d = IDLE;
            ack_d   = 1'b0;
          end
        end else if (lat_q == '0) begin
          ack_d = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.wdata_ready = (state_q == WDATA);
  assign bus.resp_valid  = (state_q == RDATA) | ack_q;
  assign bus.resp_last   = ((state_q == RDATA) && (beat_q == LAST_BEAT)) | ack_q;
  assign bus.resp_data   = rdata_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: random and directed traffic, scoreboard checked.
// Expected beats come from a word-array model of the memory.
module tb_line_mem_responder;
  localparam int DW  = 1024;
  localparam int NB  = 4;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_mem_responder_if bus();

  line_mem_responder #(
    .DEPTH_WORDS(DW),
    .BEATS(NB),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          ecyc;
  } exp_t;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          rmode = 0;
  logic [31:0] model [DW];
  exp_t        q [$];
  logic [31:0] wd [NB];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lidx(logic [31:0] a);
    int w;
    w = int'((a >> 2) % DW);
    return w - (w % NB);
  endfunction

  // Monitor: owns resp_ready, pops the scoreboard on every response handshake.
  initial begin
    logic        r;
    logic        stall_p;
    logic [31:0] held_d;
    logic        held_l;
    int          bidx;
    int          scnt;
    exp_t        e;
    stall_p = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    bidx    = 0;
    scnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_p = 1'b0;
        bidx    = 0;
        scnt    = 0;
      end else begin
        if (rmode == 0) begin
          r = 1'b1;
        end else if (rmode == 1) begin
          r = ($urandom_range(0, 3) != 0);
        end else begin
          r = 1'b1;
          if (bus.resp_valid && bidx == 1 && scnt < 3) begin
            r = 1'b0;
            scnt++;
          end
        end
        bus.resp_ready = r;
        if (stall_p) begin
          chk("hold_valid", 32'(bus.resp_valid), 32'd1);
          chk("hold_data", bus.resp_data, held_d);
          chk("hold_last", 32'(bus.resp_last), 32'(held_l));
        end
        if (bus.resp_valid && r) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h want none", bus.resp_data);
          end else begin
            e = q.pop_front();
            chk("resp_data", bus.resp_data, e.data);
            chk("resp_last", 32'(bus.resp_last), 32'(e.last));
            if (e.ecyc >= 0) chk("beat_cycle", cyc, e.ecyc);
          end
          if (bus.resp_last) begin
            bidx = 0;
            scnt = 0;
          end else begin
            bidx++;
          end
        end
        stall_p = bus.resp_valid && !r;
        held_d  = bus.resp_data;
        held_l  = bus.resp_last;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_timeout: got 0 want 1");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_read(logic [31:0] a, bit timed);
    int   b;
    int   t;
    exp_t e;
    b = lidx(a);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    t = cyc + 1;
    for (int i = 0; i < NB; i++) begin
      e.data = model[b + i];
      e.last = (i == NB - 1);
      e.ecyc = timed ? t + LAT + i : -1;
      q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
  endtask

  // gap: 0 none, 1 random, 2 one idle cycle after beat 1.
  // nb < NB stops after nb beats and resets the responder mid-line.
  task automatic do_write(logic [31:0] a, input logic [31:0] d [NB],
                          int gap, bit timed, int nb);
    int   b;
    int   w;
    bit   g;
    exp_t e;
    b = lidx(a);
    w = 0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      g = (gap == 1) ? 1'($urandom_range(0, 1)) : (gap == 2 && i == 2);
      if (g) begin
        bus.wdata_valid = 1'b0;
        @(negedge clk);
      end
      chk("wdata_ready", 32'(bus.wdata_ready), 32'd1);
      bus.wdata_valid = 1'b1;
      bus.wdata       = d[i];
      w = cyc + 1;
      @(negedge clk);
      model[b + i] = d[i];
    end
    bus.wdata_valid = 1'b0;
    if (nb == NB) begin
      e.data = '0;
      e.last = 1'b1;
      e.ecyc = timed ? w + LAT : -1;
      q.push_back(e);
    end else begin
      rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_data", bus.resp_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.resp_ready  = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      #1;
      chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("reset_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    end
    @(negedge clk);

    rmode = 1;
    for (int l = 0; l < DW / NB; l++) begin
      for (int i = 0; i < NB; i++) wd[i] = $urandom;
      do_write(32'(l * NB * 4), wd, 1, 1'b0, NB);
    end
    wait_drain();

    rmode = 0;
    wd = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_write(32'h20, wd, 0, 1'b1, NB);
    wait_drain();
    do_read(32'h24, 1'b1);
    wait_drain();

    wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(32'h40, wd, 2, 1'b1, NB);
    wait_drain();
    do_read(32'h40, 1'b1);
    wait_drain();

    rmode = 2;
    do_read(32'h24, 1'b0);
    wait_drain();
    rmode = 0;

    do_read(32'h30, 1'b1);
    for (int n = 0; n < 40 && !bus.resp_valid; n++) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h100;
    for (int n = 0; n < 3; n++) begin
      chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    wait_drain();

    do_read(32'h1024, 1'b1);
    wait_drain();

    wd = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    do_write(32'h80, wd, 0, 1'b0, 2);
    do_read(32'h80, 1'b1);
    wait_drain();

    rmode = 1;
    repeat (80) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < NB; i++) wd[i] = $urandom;
        do_write($urandom, wd, 1, 1'b0, NB);
      end else begin
        do_read($urandom, 1'b0);
      end
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
